// File: rtl/pll_fbdsel_sequencer_if.sv
// Request channel into the rPLL FBDSEL sequencer.
// Latency: wires only; the transfer happens on a cycle with req_valid & req_ready.
// Backpressure: the source holds req_valid and req_mult until req_ready is seen high.
//
// Signals:
//   req_valid  master -> slave  multiplier change request
//   req_mult   master -> slave  requested multiplier N (legal 1..64)
//   req_ready  slave  -> master sequencer can take a request (IDLE or ERR)
interface pll_fbdsel_sequencer_if;
  logic       req_valid;
  logic [6:0] req_mult;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_mult,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_mult,
    output req_ready
  );
endinterface

// File: rtl/pll_fbdsel_sequencer.sv
// Purpose: loads the rPLL FBDSEL port, pulses the PLL reset and waits for a stable lock.
// Latency: accept -> done is SETTLE_CYC + 2 + LOCK_STABLE + 1 cycles at best.
// Backpressure: req_ready only in IDLE/ERR; requests made while busy wait, held by the source.
//
// Ports:
//   clk        reference clock (same clock as the PLL clkin, never the PLL output)
//   rst_n      asynchronous active-low reset
//   req        request channel (req_valid, req_mult, req_ready)
//   fbdsel     to PLL FBDSEL, encoded as 64 - N
//   pll_reset  to PLL RESET, active high
//   pll_lock   PLL LOCK, asynchronous, synchronised here with two flops
//   locked     IDLE with synchronised lock high
//   busy       sequence in progress (every state except IDLE and ERR)
//   done       one-cycle pulse when a sequence reaches stable lock
//   err        sticky timeout / illegal-N flag, cleared by the next accepted legal request
//   cur_mult   multiplier currently programmed
module pll_fbdsel_sequencer #(
  parameter int unsigned DEFAULT_MULT = 1,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pll_fbdsel_sequencer_if.slave        req,
  output logic [5:0]                   fbdsel,
  output logic                         pll_reset,
  input  logic                         pll_lock,
  output logic                         locked,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [6:0]                   cur_mult
);

  localparam int unsigned HOLD_W = $clog2(SETTLE_CYC);
  localparam int unsigned STB_W  = $clog2(LOCK_STABLE + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE_CYC - 1);
  localparam logic [STB_W-1:0]  STB_DONE  = STB_W'(LOCK_STABLE);
  localparam logic [15:0]       TMO_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [6:0]        DEF_MULT  = 7'(DEFAULT_MULT);
  localparam logic [5:0]        DEF_FBD   = 6'(64 - DEFAULT_MULT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD      = 2'd1,
    ST_WAIT_LOCK = 2'd2,
    ST_ERR       = 2'd3
  } state_t;

  state_t            state_q;
  logic [5:0]        fbdsel_q;
  logic [6:0]        cur_mult_q;
  logic              pll_reset_q;
  logic              done_q;
  logic              err_q;
  logic              locked_q;
  logic              busy_q;
  logic              req_ready_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [STB_W-1:0]  stable_cnt_q;
  logic [15:0]       tmo_cnt_q;
  logic              sync1_q;
  logic              lock_s_q;

  logic              req_fire_d;
  logic              req_legal_d;
  logic [5:0]        req_fbdsel_d;

  assign req_fire_d   = req.req_valid & req_ready_q;
  assign req_legal_d  = (req.req_mult != 7'd0) && (req.req_mult <= 7'd64);
  // N=64 wraps to 6'h00, N=1 gives 6'h3F.
  assign req_fbdsel_d = 6'(7'd64 - req.req_mult);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_LOCK;
      fbdsel_q     <= DEF_FBD;
      cur_mult_q   <= DEF_MULT;
      pll_reset_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b1;
      req_ready_q  <= 1'b0;
      hold_cnt_q   <= '0;
      stable_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      sync1_q      <= 1'b0;
      lock_s_q     <= 1'b0;
    end else begin
      // While the PLL is held in reset its LOCK output is meaningless, so the
      // synchroniser is flushed; a fresh lock must ripple through both flops.
      if (state_q == ST_HOLD) begin
        sync1_q  <= 1'b0;
        lock_s_q <= 1'b0;
      end else begin
        sync1_q  <= pll_lock;
        lock_s_q <= sync1_q;
      end

      done_q   <= 1'b0;
      locked_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_ERR: begin
          // locked is registered, so it follows the value lock_s_q is about to take.
          if (state_q == ST_IDLE) begin
            locked_q <= sync1_q;
          end
          if (req_fire_d) begin
            if (req_legal_d) begin
              fbdsel_q    <= req_fbdsel_d;
              cur_mult_q  <= req.req_mult;
              err_q       <= 1'b0;
              hold_cnt_q  <= '0;
              pll_reset_q <= 1'b1;
              busy_q      <= 1'b1;
              req_ready_q <= 1'b0;
              locked_q    <= 1'b0;
              state_q     <= ST_HOLD;
            end else begin
              // Illegal N leaves the programmed multiplier alone.
              err_q <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            pll_reset_q  <= 1'b0;
            stable_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            state_q      <= ST_WAIT_LOCK;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          // Stable lock is checked first so it wins a tie with the timeout.
          if (stable_cnt_q == STB_DONE) begin
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            locked_q    <= sync1_q;
            state_q     <= ST_IDLE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            err_q       <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_ERR;
          end else begin
            tmo_cnt_q    <= tmo_cnt_q + 16'd1;
            stable_cnt_q <= lock_s_q ? (stable_cnt_q + 1'b1) : '0;
          end
        end

        default: begin
          pll_reset_q  <= 1'b0;
          busy_q       <= 1'b1;
          req_ready_q  <= 1'b0;
          stable_cnt_q <= '0;
          tmo_cnt_q    <= '0;
          state_q      <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

  assign fbdsel        = fbdsel_q;
  assign cur_mult      = cur_mult_q;
  assign pll_reset     = pll_reset_q;
  assign done          = done_q;
  assign err           = err_q;
  assign locked        = locked_q;
  assign busy          = busy_q;
  assign req.req_ready = req_ready_q;

  // The PLL reset pulse exists only in HOLD, and FBDSEL never moves under it.
  a_hold_reset : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_HOLD) |-> pll_reset_q);
  a_hold_fbdsel : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_HOLD) |=> $stable(fbdsel_q));

endmodule

// File: tb/tb_pll_fbdsel_sequencer.sv
module tb_pll_fbdsel_sequencer;
  localparam int SETTLE = 16;
  localparam int STABLE = 8;
  localparam int TMO    = 100;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       pll_lock = 1'b0;
  logic [5:0] fbdsel;
  logic       pll_reset, locked, busy, done, err;
  logic [6:0] cur_mult;

  pll_fbdsel_sequencer_if rq();

  pll_fbdsel_sequencer #(
    .DEFAULT_MULT(1),
    .SETTLE_CYC  (SETTLE),
    .LOCK_STABLE (STABLE),
    .LOCK_TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (rq.slave),
    .fbdsel   (fbdsel),
    .pll_reset(pll_reset),
    .pll_lock (pll_lock),
    .locked   (locked),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cur_mult (cur_mult)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // PLL lock model: counts cycles since pll_reset was last high.
  // mode 0: lock from count >= dly; mode 1: never locks;
  // mode 2: high for 3 cycles from dly, low 1 cycle, then high for good.
  int lock_mode = 0;
  int lock_dly  = 5;
  int lk_cnt    = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n || pll_reset) lk_cnt = 0;
    else if (lk_cnt < 1000000) lk_cnt++;
    case (lock_mode)
      1:       pll_lock = 1'b0;
      2:       pll_lock = ((lk_cnt >= lock_dly) && (lk_cnt <= lock_dly + 2)) || (lk_cnt >= lock_dly + 4);
      default: pll_lock = (lk_cnt >= lock_dly);
    endcase
  end

  typedef struct {
    logic [6:0] mult;
    int         dly;
    int         mode;
    bit         legal;
    logic [5:0] exp_fbdsel;
    logic [6:0] exp_cur;
    bit         exp_done;
    int         exp_k;     // cycles from pll_reset falling to done/err
  } vec_t;

  vec_t tbl [12];

  logic [5:0] mdl_fbdsel;
  logic [6:0] mdl_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: legal N gives fbdsel 64-N; lock must stay high for 2 sync
  // cycles plus STABLE cycles, and that has to finish within TMO cycles.
  function automatic vec_t model_req(input logic [6:0] m, input int dly, input int mode);
    vec_t v;
    int   lock_at;
    v.mult       = m;
    v.dly        = dly;
    v.mode       = mode;
    v.legal      = (m >= 7'd1) && (m <= 7'd64);
    v.exp_fbdsel = mdl_fbdsel;
    v.exp_cur    = mdl_cur;
    v.exp_done   = 1'b0;
    v.exp_k      = 0;
    if (v.legal) begin
      v.exp_fbdsel = 6'(64 - int'(m));
      v.exp_cur    = m;
      lock_at      = (mode == 2) ? dly + 4 : dly;
      if (mode != 1 && lock_at + 2 + STABLE <= TMO) begin
        v.exp_done = 1'b1;
        v.exp_k    = lock_at + 2 + STABLE;
      end else begin
        v.exp_k = TMO;
      end
    end
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (rq.req_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " req_ready"}, 32'(rq.req_ready), 1);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int n;
    int k;
    bit fb_ok;
    lock_mode = v.mode;
    lock_dly  = v.dly;
    wait_ready(tag);
    rq.req_valid = 1'b1;
    rq.req_mult  = v.mult;
    @(negedge clk);
    rq.req_valid = 1'b0;
    if (!v.legal) begin
      chk({tag, " illegal err"},       32'(err),          1);
      chk({tag, " illegal pll_reset"}, 32'(pll_reset),    0);
      chk({tag, " illegal fbdsel"},    32'(fbdsel),       32'(v.exp_fbdsel));
      chk({tag, " illegal cur_mult"},  32'(cur_mult),     32'(v.exp_cur));
      chk({tag, " illegal req_ready"}, 32'(rq.req_ready), 1);
    end else begin
      chk({tag, " pll_reset rise"}, 32'(pll_reset), 1);
      chk({tag, " fbdsel"},         32'(fbdsel),    32'(v.exp_fbdsel));
      chk({tag, " cur_mult"},       32'(cur_mult),  32'(v.exp_cur));
      chk({tag, " err cleared"},    32'(err),       0);
      n     = 0;
      fb_ok = 1'b1;
      while (pll_reset === 1'b1 && n < 100) begin
        n++;
        if (fbdsel !== v.exp_fbdsel) fb_ok = 1'b0;
        @(negedge clk);
      end
      chk({tag, " pll_reset width"}, 32'(n),     32'(SETTLE));
      chk({tag, " fbdsel held"},     32'(fb_ok), 1);
      k = 0;
      while (done !== 1'b1 && err !== 1'b1 && k < 300) begin
        @(negedge clk);
        k++;
      end
      chk({tag, " done"},   32'(done), 32'(v.exp_done));
      chk({tag, " err"},    32'(err),  32'(!v.exp_done));
      chk({tag, " cycles"}, 32'(k),    32'(v.exp_k));
      chk({tag, " busy"},   32'(busy), 0);
      if (v.exp_done) begin
        chk({tag, " locked"}, 32'(locked), 1);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 0);
      end else begin
        chk({tag, " locked in err"}, 32'(locked), 0);
      end
    end
    mdl_fbdsel = v.exp_fbdsel;
    mdl_cur    = v.exp_cur;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_done;
    int   n;
    bit   ok;
    vec_t v;
    logic [6:0] m;
    int   r;

    //            mult   dly mode legal fbdsel cur   done k
    tbl[0]  = '{7'd8,   10, 0, 1'b1, 6'h38, 7'd8,  1'b1, 20};
    tbl[1]  = '{7'd0,   10, 0, 1'b0, 6'h38, 7'd8,  1'b0, 0};
    tbl[2]  = '{7'd65,  10, 0, 1'b0, 6'h38, 7'd8,  1'b0, 0};
    tbl[3]  = '{7'd4,    1, 0, 1'b1, 6'h3C, 7'd4,  1'b1, 11};
    tbl[4]  = '{7'd64,   3, 0, 1'b1, 6'h00, 7'd64, 1'b1, 13};
    tbl[5]  = '{7'd64,   2, 0, 1'b1, 6'h00, 7'd64, 1'b1, 12};
    tbl[6]  = '{7'd1,    0, 1, 1'b1, 6'h3F, 7'd1,  1'b0, 100};
    tbl[7]  = '{7'd127,  0, 1, 1'b0, 6'h3F, 7'd1,  1'b0, 0};
    tbl[8]  = '{7'd20,  90, 0, 1'b1, 6'h2C, 7'd20, 1'b1, 100};
    tbl[9]  = '{7'd33,  91, 0, 1'b1, 6'h1F, 7'd33, 1'b0, 100};
    tbl[10] = '{7'd2,    5, 2, 1'b1, 6'h3E, 7'd2,  1'b1, 19};
    tbl[11] = '{7'd63,   1, 0, 1'b1, 6'h01, 7'd63, 1'b1, 11};

    rq.req_valid = 1'b0;
    rq.req_mult  = 7'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst fbdsel",    32'(fbdsel),       32'h3F);
    chk("rst cur_mult",  32'(cur_mult),     1);
    chk("rst pll_reset", 32'(pll_reset),    0);
    chk("rst done",      32'(done),         0);
    chk("rst err",       32'(err),          0);
    chk("rst locked",    32'(locked),       0);
    chk("rst busy",      32'(busy),         1);
    chk("rst req_ready", 32'(rq.req_ready), 0);

    // Power-up lock wait for the default multiplier.
    lock_mode = 0;
    lock_dly  = 5;
    rst_n     = 1'b1;
    n_done    = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("boot done pulses", 32'(n_done),       1);
    chk("boot locked",      32'(locked),       1);
    chk("boot fbdsel",      32'(fbdsel),       32'h3F);
    chk("boot cur_mult",    32'(cur_mult),     1);
    chk("boot busy",        32'(busy),         0);
    chk("boot req_ready",   32'(rq.req_ready), 1);
    mdl_fbdsel = 6'h3F;
    mdl_cur    = 7'd1;

    for (int i = 0; i < 12; i++) begin
      apply_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Loss of lock in IDLE: locked drops, no automatic re-sequence.
    lock_mode = 1;
    repeat (3) @(negedge clk);
    chk("lol locked", 32'(locked), 0);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (pll_reset !== 1'b0 || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    chk("lol no resequence", 32'(ok), 1);
    lock_mode = 0;
    repeat (4) @(negedge clk);
    chk("lol relocked", 32'(locked), 1);

    // Randomised requests against the reference model.
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      m = (r == 0) ? 7'($urandom_range(65, 127)) : 7'($urandom_range(0, 66));
      r = $urandom_range(0, 9);
      v = model_req(m, $urandom_range(1, 95), (r == 0) ? 1 : ((r == 1) ? 2 : 0));
      apply_vec(v, $sformatf("rnd%0d", i));
    end

    // Async reset in the middle of HOLD with a request held valid.
    lock_mode = 0;
    lock_dly  = 3;
    wait_ready("mid");
    rq.req_valid = 1'b1;
    rq.req_mult  = 7'd10;
    @(negedge clk);
    chk("mid fbdsel",    32'(fbdsel),    32'h36);
    chk("mid pll_reset", 32'(pll_reset), 1);
    rq.req_mult = 7'd50;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rq.req_ready !== 1'b0 || fbdsel !== 6'h36 || pll_reset !== 1'b1) ok = 1'b0;
    end
    chk("mid held req ignored", 32'(ok), 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst pll_reset", 32'(pll_reset),    0);
    chk("mid rst fbdsel",    32'(fbdsel),       32'h3F);
    chk("mid rst cur_mult",  32'(cur_mult),     1);
    chk("mid rst busy",      32'(busy),         1);
    chk("mid rst req_ready", 32'(rq.req_ready), 0);
    rq.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid relock done",     32'(done),     1);
    chk("mid relock cur_mult", 32'(cur_mult), 1);
    chk("mid relock locked",   32'(locked),   1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
